rr_mux_nx1: RTL and testbench

- Parametrised successor to the 4:1 mux: N-input, WIDTH-bit, registered multiplexer with valid/ready handshakes on every input and on the output.
- Two modes:
  - Round-robin: fair arbitration across all requesting channels.
  - Forced-select: classic mux behaviour, only the channel on `sel` is passed.
- Sits between N producer streams and one consumer, e.g. a shared bus or an output port.

---
 rtl/rr_mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 88 ++++++++
 rtl/rr_mux_nx1.sv | 82 ++++++++
 tb/tb_rr_mux_nx1.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the N:1 round-robin / forced-select multiplexer.
package rr_mux_pkg;

    // Arbitration mode as seen on the `mode` port.
    typedef enum logic {
        MODE_RR     = 1'b0,
        MODE_FORCED = 1'b1
    } mode_t;

    // Low bit of channel `ch` inside a flattened {ch N-1, ..., ch 0} data bus.
    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Channel arbiter: rotating-priority search in round-robin mode, direct
// select in forced mode. Owns the round-robin pointer.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             advance,
    output logic             grant_valid,
    output logic [SEL_W-1:0] g
);

    mode_t            cur_mode;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_g;
    logic             fs_valid;

    assign cur_mode = mode_t'(mode);

    // Rotating priority: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        rr_valid = 1'b0;
        rr_g     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!rr_valid && req[i] && (i >= 32'(ptr))) begin
                rr_valid = 1'b1;
                rr_g     = SEL_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!rr_valid && req[i] && (i < 32'(ptr))) begin
                rr_valid = 1'b1;
                rr_g     = SEL_W'(i);
            end
        end
    end

    // Forced select: an out-of-range sel matches no channel, so it simply never grants.
    always_comb begin
        fs_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if ((32'(sel) == i) && req[i]) begin
                fs_valid = 1'b1;
            end
        end
    end

    // Pick the grant source for the current mode.
    always_comb begin
        if (cur_mode == MODE_FORCED) begin
            grant_valid = fs_valid;
            g           = sel;
        end else begin
            grant_valid = rr_valid;
            g           = rr_g;
        end
    end

    // Pointer moves past the granted channel only on a round-robin load.
    always_comb begin
        ptr_next = ptr;
        if (advance && (cur_mode == MODE_RR)) begin
            if (32'(g) == 32'(N - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = g + SEL_W'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/rr_mux_nx1.sv
// N-input registered multiplexer with valid/ready on every channel and on
// the output; arbitration is round-robin or forced by `sel`.
module rr_mux_nx1
    import rr_mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready
);

    logic             grant_valid;
    logic [SEL_W-1:0] g;
    logic             load;
    logic [WIDTH-1:0] g_data;

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (in_valid),
        .mode        (mode),
        .sel         (sel),
        .advance     (load),
        .grant_valid (grant_valid),
        .g           (g)
    );

    // Accept a word when the output slot is empty or being drained this cycle.
    // rst gates it so no channel sees ready while reset is held.
    always_comb begin
        load = !rst && (!out_valid || out_ready) && grant_valid;
    end

    // One-hot ready back to the granted producer.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (load && (g == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Select the granted channel's data slice.
    always_comb begin
        g_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (g == SEL_W'(i)) begin
                g_data = in_data[slice_lo(i, WIDTH) +: WIDTH];
            end
        end
    end

    // Output register: load replaces (even while draining), otherwise drain clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_ch    <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Directed bench for rr_mux_nx1 with a cycle model and output scoreboard.
module tb_rr_mux_nx1;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N*8-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             mode;
    logic [1:0]       sel;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [1:0]       out_ch;
    logic             out_ready;

    // Second instance with N=3 for out-of-range select
    logic [2:0]       iv3;
    logic [23:0]      id3;
    logic [2:0]       ir3;
    logic             mode3;
    logic [1:0]       sel3;
    logic             ov3;
    logic [7:0]       od3;
    logic [1:0]       och3;
    logic             ordy3;

    int total = 0;
    int bad   = 0;

    rr_mux_nx1 #(.N(N), .WIDTH(WIDTH)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
    );

    rr_mux_nx1 #(.N(3), .WIDTH(8)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_data(id3),
        .in_ready(ir3), .mode(mode3), .sel(sel3), .out_valid(ov3),
        .out_data(od3), .out_ch(och3), .out_ready(ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle model of the N=4 instance, evaluated on the falling edge.
    int         m_ptr = 0;
    bit         m_ov  = 0;
    logic [9:0] sb[$];
    bit         p_ov  = 0;
    bit         p_rdy = 0;
    logic [7:0] p_data = '0;
    bit         gv, ld;
    int         gg, c;
    logic [3:0] er;
    logic [9:0] ent;

    always @(negedge clk) begin
        if (rst) begin
            m_ptr = 0;
            m_ov  = 0;
            p_ov  = 0;
            sb.delete();
        end else begin
            gv = 0;
            gg = 0;
            if (mode == 1'b0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!gv && in_valid[c]) begin
                        gv = 1;
                        gg = c;
                    end
                end
            end else if (in_valid[sel]) begin
                gv = 1;
                gg = int'(sel);
            end
            ld = (!m_ov || out_ready) && gv;
            er = ld ? (4'b0001 << gg) : 4'b0000;
            chk("m_in_ready", 32'(in_ready), 32'(er));
            chk("m_out_valid", 32'(out_valid), 32'(m_ov));
            if (p_ov && !p_rdy) chk("m_hold_data", 32'(out_data), 32'(p_data));
            if (m_ov && out_ready) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'(1));
                if (sb.size() > 0) begin
                    ent = sb.pop_front();
                    chk("sb_ch", 32'(out_ch), 32'(ent[9:8]));
                    chk("sb_data", 32'(out_data), 32'(ent[7:0]));
                end
            end
            if (ld) sb.push_back({2'(gg), in_data[gg*8 +: 8]});
            p_ov   = out_valid;
            p_rdy  = out_ready;
            p_data = out_data;
            if (ld && mode == 1'b0) m_ptr = (gg + 1) % N;
            m_ov = ld ? 1'b1 : (out_ready ? 1'b0 : m_ov);
        end
    end

    initial begin
        logic [7:0] ed;
        int         ec;

        rst = 1; in_valid = '0; in_data = '0; mode = 0; sel = '0; out_ready = 0;
        iv3 = '0; id3 = '0; mode3 = 0; sel3 = '0; ordy3 = 0;

        // Reset values, and no ready while reset is held even with requests
        #1;
        in_valid = '1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_ch", 32'(out_ch), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        tick();
        tick();
        rst = 0; in_valid = '0;

        // Idle after reset
        repeat (3) begin
            @(negedge clk);
            chk("idle_out_valid", 32'(out_valid), 32'(0));
            chk("idle_out_data", 32'(out_data), 32'(0));
            chk("idle_in_ready", 32'(in_ready), 32'(0));
        end
        tick();

        // Round-robin fairness, all channels valid
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid = '1; out_ready = 1; mode = 0;
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            ed = 8'hA0 + 8'(j % 4);
            chk("rr_ch", 32'(out_ch), 32'(j % 4));
            chk("rr_data", 32'(out_data), 32'(ed));
            chk("rr_valid", 32'(out_valid), 32'(1));
        end
        tick();

        // Move pointer to 3 via a lone ch2 request, then skip pattern 0101
        in_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0101;
        @(posedge clk);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            ec = (j == 1) ? 2 : 0;
            ed = (j == 1) ? 8'hB2 : 8'hB0;
            chk("wrap_ch", 32'(out_ch), 32'(ec));
            chk("wrap_data", 32'(out_data), 32'(ed));
            chk("wrap_no_odd_ready", 32'(in_ready & 4'b1010), 32'(0));
        end
        tick();
        in_valid = '0;
        tick();

        // Backpressure: hold 55 for five cycles with ch1 waiting
        in_data = {8'h00, 8'h00, 8'h66, 8'h55};
        in_valid = 4'b0001; out_ready = 0;
        tick();
        in_valid = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            chk("bp_data", 32'(out_data), 32'(8'h55));
            chk("bp_ch", 32'(out_ch), 32'(0));
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
        end
        tick();
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'(4'b0010));
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("bp_next_data", 32'(out_data), 32'(8'h66));
        chk("bp_next_ch", 32'(out_ch), 32'(1));
        chk("bp_next_valid", 32'(out_valid), 32'(1));
        tick();

        // Forced select of ch2 with every channel requesting
        mode = 1; sel = 2'd2;
        in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        in_valid = '1;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("fs_ch", 32'(out_ch), 32'(2));
            chk("fs_data", 32'(out_data), 32'(8'hC2));
            chk("fs_in_ready", 32'(in_ready), 32'(4'b0100));
        end
        tick();
        in_valid = 4'b1011;
        @(posedge clk);
        @(negedge clk);
        chk("fs_drain_valid", 32'(out_valid), 32'(0));
        chk("fs_drain_ready", 32'(in_ready), 32'(0));
        tick();

        // N=3: sel=3 grants nothing; sel=1 then grants
        mode3 = 1; sel3 = 2'd3; iv3 = 3'b111; id3 = {8'h93, 8'h92, 8'h91}; ordy3 = 1;
        repeat (3) begin
            @(negedge clk);
            chk("n3_oor_ready", 32'(ir3), 32'(0));
            chk("n3_oor_valid", 32'(ov3), 32'(0));
        end
        tick();
        sel3 = 2'd1;
        @(posedge clk);
        @(negedge clk);
        chk("n3_sel1_valid", 32'(ov3), 32'(1));
        chk("n3_sel1_ch", 32'(och3), 32'(1));
        chk("n3_sel1_data", 32'(od3), 32'(8'h92));
        tick();
        iv3 = '0;

        // Back to round-robin: pointer untouched by forced mode (still 2)
        mode = 0; in_valid = '1;
        @(posedge clk);
        @(negedge clk);
        chk("ptr_kept_ch", 32'(out_ch), 32'(2));
        chk("ptr_kept_data", 32'(out_data), 32'(8'hC2));
        tick();
        out_ready = 0; in_valid = '0;
        @(negedge clk);
        chk("stall_ch", 32'(out_ch), 32'(3));
        chk("stall_valid", 32'(out_valid), 32'(1));

        // Mode switch while stalled: held word kept, forced mode governs next load
        tick();
        mode = 1; sel = 2'd1;
        in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        in_valid = '1;
        repeat (2) begin
            @(negedge clk);
            chk("msw_hold_ch", 32'(out_ch), 32'(3));
            chk("msw_hold_data", 32'(out_data), 32'(8'hC3));
            chk("msw_in_ready", 32'(in_ready), 32'(0));
        end
        tick();
        out_ready = 1;
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("msw_next_ch", 32'(out_ch), 32'(1));
        chk("msw_next_data", 32'(out_data), 32'(8'hD1));

        // Reset mid-transfer
        tick();
        mode = 0; in_valid = 4'b0100; out_ready = 0;
        in_data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        @(posedge clk);
        #3;
        chk("pre_rst_valid", 32'(out_valid), 32'(1));
        rst = 1; in_valid = '1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_data", 32'(out_data), 32'(0));
        chk("mid_rst_ch", 32'(out_ch), 32'(0));
        chk("mid_rst_ready", 32'(in_ready), 32'(0));
        tick();
        chk("mid_rst_ready_edge", 32'(in_ready), 32'(0));
        rst = 0; out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("ptr_reset_ch", 32'(out_ch), 32'(0));
        chk("ptr_reset_data", 32'(out_data), 32'(8'hE0));
        tick();
        in_valid = '0;
        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
